// File: rtl/matrix_key_scan_pkg.sv
// matrix_key_scan_pkg: shared FSM encodings, keypad geometry and timing defaults for the key scanner.
package matrix_key_scan_pkg;
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_SCAN     = 3'd2,
        ST_REPORT   = 3'd3,
        ST_HOLD     = 3'd4
    } state_e;

    localparam int ROWS              = 4;
    localparam int COLS              = 4;
    localparam int DB_CYCLES_DEF     = 1_000_000;
    localparam int SETTLE_CYCLES_DEF = 16;

    // Index of the lowest-numbered column pulled low (columns are active-low).
    function automatic logic [1:0] lowest_low(input logic [COLS-1:0] c);
        return !c[0] ? 2'd0 : !c[1] ? 2'd1 : !c[2] ? 2'd2 : 2'd3;
    endfunction
endpackage

// File: rtl/matrix_key_scan_sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous pin inputs, resetting to a configurable value.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/matrix_key_scan.sv
// matrix_key_scan: 4x4 active-low keypad scanner with press/release debounce and one-cycle key report.
module matrix_key_scan
    import matrix_key_scan_pkg::*;
#(
    parameter int DB_CYCLES     = DB_CYCLES_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [3:0] col_n_i,
    output logic [3:0] row_n_o,
    output logic       key_valid_o,
    output logic [3:0] key_code_o,
    output logic       key_held_o
);
    localparam int CW = $clog2(DB_CYCLES > SETTLE_CYCLES ? DB_CYCLES : SETTLE_CYCLES);
    localparam logic [CW-1:0] DB_LAST     = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [1:0]    ROW_LAST    = 2'(ROWS - 1);
    localparam logic [COLS-1:0] NONE      = '1;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      row_q, row_d;
    logic [3:0]      code_q, code_d;
    logic [COLS-1:0] col_s, col_prev_q;

    sync_2ff #(.WIDTH(COLS), .RST_VAL(NONE)) u_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (col_n_i),
        .q_o     (col_s)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            row_q      <= '0;
            code_q     <= '0;
            col_prev_q <= NONE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            code_q     <= code_d;
            col_prev_q <= col_s;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        row_d   = row_q;
        code_d  = code_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                state_d = col_s != NONE ? ST_DEBOUNCE : ST_IDLE;
            end
            ST_DEBOUNCE: begin
                if (col_s == NONE) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (col_s != col_prev_q) begin
                    cnt_d = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                    row_d   = '0;
                end
            end
            ST_SCAN: begin
                // Columns are only trusted once the row has settled through the synchroniser.
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d = '0;
                    if (col_s != NONE) begin
                        state_d = ST_REPORT;
                        code_d  = {row_q, lowest_low(col_s)};
                    end else if (row_q == ROW_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            ST_REPORT: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
            end
            ST_HOLD: begin
                if (col_s != NONE) begin
                    cnt_d = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign row_n_o     = state_q == ST_SCAN ? ~(4'b0001 << row_q) : 4'b0000;
    assign key_valid_o = state_q == ST_REPORT;
    assign key_held_o  = state_q == ST_REPORT || state_q == ST_HOLD;
    assign key_code_o  = code_q;
endmodule

// File: tb/tb_matrix_key_scan.sv
// tb_matrix_key_scan: randomized keypad stimulus with a queue scoreboard for key pulses and release timing.
module tb_matrix_key_scan;
    localparam int DB = 8;
    localparam int ST = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  col_n, row_n, key_code;
    logic        key_valid, key_held;
    logic [15:0] pressed = '0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        int         cyc;
        logic [3:0] code;
    } pulse_t;

    pulse_t exp_pulse[$];
    int     exp_drop[$];
    pulse_t p;
    logic   held_prev = 1'b0;
    logic   valid_prev = 1'b0;

    matrix_key_scan #(.DB_CYCLES(DB), .SETTLE_CYCLES(ST)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .col_n_i     (col_n),
        .row_n_o     (row_n),
        .key_valid_o (key_valid),
        .key_code_o  (key_code),
        .key_held_o  (key_held)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // A pressed key shorts its column to its row only while that row is driven low.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulse lands in this cycle counting the press cycle as cycle 1: sync, idle, debounce, settle per row, report.
    function automatic int lat(input int code);
        return 2 + 1 + DB + (code / 4 + 1) * ST + 1;
    endfunction

    function automatic int winner(input logic [15:0] keys);
        int w = 16;
        for (int i = 15; i >= 0; i--) if (keys[i]) w = i;
        return w;
    endfunction

    task automatic press_release(input logic [15:0] keys, input int extra, input logic [15:0] later);
        int code;
        pulse_t e;
        code   = winner(keys);
        e.cyc  = cyc + lat(code) - 1;
        e.code = code[3:0];
        exp_pulse.push_back(e);
        pressed = keys;
        tick(lat(code) + 2);
        pressed = pressed | later;
        tick(extra);
        pressed = '0;
        exp_drop.push_back(cyc + 2 + DB);
        tick(2 + DB + 4);
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            if (key_valid === 1'b1) begin
                if (exp_pulse.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse code=%0d at cycle %0d, required no pulse", key_code, cyc);
                end else begin
                    p = exp_pulse.pop_front();
                    check("pulse_code", int'(key_code), int'(p.code));
                    check("pulse_cycle", cyc, p.cyc);
                end
                check("held_with_valid", int'(key_held), 1);
                check("valid_not_consecutive", int'(valid_prev), 0);
            end
            if (held_prev === 1'b1 && key_held === 1'b0) begin
                if (exp_drop.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_release at cycle %0d, required key_held still 1", cyc);
                end else begin
                    check("release_cycle", cyc, exp_drop.pop_front());
                end
            end
            held_prev  = key_held;
            valid_prev = key_valid;
        end
    end

    initial begin
        int          r_cyc;
        logic [15:0] keys, later;
        pulse_t      e;

        // Reset held for three edges while the keypad chatters.
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("rst_row_n", int'(row_n), 0);
            check("rst_valid", int'(key_valid), 0);
            check("rst_code", int'(key_code), 0);
            check("rst_held", int'(key_held), 0);
            pressed = i < 1 ? 16'($urandom) : '0;
        end
        rst_n = 1'b1;
        tick(4);

        // Clean press of (2,1) held for 40 cycles.
        press_release(16'h0200, 40 - lat(9) - 2, '0);

        // Column 0 chatters and never settles.
        for (int i = 0; i < 10; i++) begin
            pressed = pressed ^ 16'h0001;
            tick(3);
        end
        pressed = '0;
        tick(12);

        // (1,3) and (2,0) together: row 1 wins.
        press_release(16'h0180, 30, '0);

        // (3,2) released right after debounce completes.
        pressed = 16'h4000;
        tick(DB + 3);
        pressed = '0;
        tick(4 * ST + 10);

        // Reset during HOLD of (0,0) with the key still down.
        e.cyc   = cyc + lat(0) - 1;
        e.code  = 4'd0;
        exp_pulse.push_back(e);
        pressed = 16'h0001;
        tick(lat(0) + 5);
        rst_n = 1'b0;
        r_cyc = cyc;
        exp_drop.push_back(r_cyc + 1);
        e.cyc = r_cyc + 1 + lat(0) - 1;
        exp_pulse.push_back(e);
        tick(1);
        rst_n = 1'b1;
        check("midrst_held", int'(key_held), 0);
        check("midrst_row_n", int'(row_n), 0);
        check("midrst_code", int'(key_code), 0);
        check("midrst_valid", int'(key_valid), 0);
        tick(lat(0) + 5);
        pressed = '0;
        exp_drop.push_back(cyc + 2 + DB);
        tick(2 + DB + 4);

        // Random single/double presses, sometimes with an extra key arriving during HOLD.
        for (int i = 0; i < 12; i++) begin
            keys = 16'h0001 << $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) keys = keys | (16'h0001 << $urandom_range(0, 15));
            later = $urandom_range(0, 2) == 0 ? 16'h0001 << $urandom_range(0, 15) : 16'h0000;
            press_release(keys, int'($urandom_range(5, 20)), later);
        end

        check("pending_pulses", exp_pulse.size(), 0);
        check("pending_releases", exp_drop.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
